mc_control_p: RTL and testbench

Parametrised multicycle CPU control FSM, successor to the current fixed multicycle controller. Sequences fetch/decode/execute/writeback and drives datapath mux selects and enables. Adds a memory ready handshake, jump instructions, an ALU-done watchdog and an illegal-opcode/timeout trap with a vector state. Sits between instruction register/ALU/memory and the register file in the multicycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 97 +++++++++
 rtl/mc_control_p_if.sv | 38 +++
 rtl/mc_alu_watchdog.sv | 20 ++
 rtl/mc_control_p.sv | 94 +++++++++
 tb/tb_mc_control_p.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode, select and trap encodings for the multicycle controller
package mc_ctrl_pkg;
  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
    S_RWAIT, S_RWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_TRAP, S_VECTOR
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100010;
  localparam logic [5:0] OP_SW = 6'b100011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BR = 6'b110000;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [1:0] ALUB_REG = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM = 2'b10;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  typedef struct packed {
    logic memReq;
    logic memWriteEn;
    logic iorDSel;
    logic irWriteEn;
    logic pcWrite;
    logic branchEn;
    logic [1:0] pcSrcSel;
    logic aluASrcSel;
    logic [1:0] aluBSrcSel;
    logic aluStart;
    logic regDstSel;
    logic memtoRegSel;
    logic regWriteEn;
    logic trap;
  } ctrl_t;
  // Moore decode of every control line except AluOp, which depends on latched IR fields
  function automatic ctrl_t ctrlFor(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.memReq = 1'b1;
      S_LATCH: begin
        c.irWriteEn = 1'b1;
        c.pcWrite = 1'b1;
        c.aluBSrcSel = ALUB_FOUR;
      end
      S_DECODE, S_MEMADDR, S_IEXEC: begin
        c.aluASrcSel = 1'b1;
        c.aluBSrcSel = ALUB_IMM;
      end
      S_MEMRD: begin
        c.memReq = 1'b1;
        c.iorDSel = 1'b1;
        c.aluASrcSel = 1'b1;
        c.aluBSrcSel = ALUB_IMM;
      end
      S_MEMWB: begin
        c.memtoRegSel = 1'b1;
        c.regWriteEn = 1'b1;
      end
      S_MEMWR: begin
        c.memReq = 1'b1;
        c.memWriteEn = 1'b1;
        c.iorDSel = 1'b1;
      end
      S_REXEC: begin
        c.aluASrcSel = 1'b1;
        c.aluStart = 1'b1;
      end
      S_RWAIT: c.aluASrcSel = 1'b1;
      S_RWB: begin
        c.regDstSel = 1'b1;
        c.regWriteEn = 1'b1;
      end
      S_BRANCH: begin
        c.aluASrcSel = 1'b1;
        c.pcSrcSel = PC_BRANCH;
        c.branchEn = 1'b1;
      end
      S_IWB: c.regWriteEn = 1'b1;
      S_JUMP: begin
        c.pcSrcSel = PC_JUMP;
        c.pcWrite = 1'b1;
      end
      S_TRAP: c.trap = 1'b1;
      S_VECTOR: begin
        c.pcSrcSel = PC_TRAP;
        c.pcWrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/mc_control_p_if.sv
// mc_control_p_if: instruction/ALU/memory status in, datapath selects and enables out
interface mc_control_p_if #(
  parameter int OP_W = 6,
  parameter int FUNC_W = 6,
  parameter int ALUOP_W = 5
);
  logic [OP_W-1:0] Opcode;
  logic [FUNC_W-1:0] AluFunc;
  logic aludone;
  logic mem_ready;
  logic trap_clear;
  logic mem_req;
  logic MemWriteEn;
  logic IorDSel;
  logic IRWriteEn;
  logic PCWrite;
  logic BranchEn;
  logic [1:0] PCSrcSel;
  logic ALUASrcSel;
  logic [1:0] ALUBSrcSel;
  logic [ALUOP_W-1:0] AluOp;
  logic alu_start;
  logic RegDstSel;
  logic MemtoRegSel;
  logic RegWriteEn;
  logic trap;
  logic [1:0] trap_cause;
  modport master (
    input Opcode, AluFunc, aludone, mem_ready, trap_clear,
    output mem_req, MemWriteEn, IorDSel, IRWriteEn, PCWrite, BranchEn, PCSrcSel, ALUASrcSel,
    output ALUBSrcSel, AluOp, alu_start, RegDstSel, MemtoRegSel, RegWriteEn, trap, trap_cause
  );
  modport slave (
    output Opcode, AluFunc, aludone, mem_ready, trap_clear,
    input mem_req, MemWriteEn, IorDSel, IRWriteEn, PCWrite, BranchEn, PCSrcSel, ALUASrcSel,
    input ALUBSrcSel, AluOp, alu_start, RegDstSel, MemtoRegSel, RegWriteEn, trap, trap_cause
  );
endinterface

// File: rtl/mc_alu_watchdog.sv
// mc_alu_watchdog: counts ALU wait cycles and flags the cycle that reaches the limit
module mc_alu_watchdog #(
  parameter int ALU_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  input logic clear,
  input logic enable,
  output logic expire
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  logic [CW-1:0] count;
  // count holds completed wait cycles, so the current one is the last when it equals limit-1
  assign expire = enable && count == CW'(ALU_TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expire) count <= count + 1'b1;
  end
endmodule

// File: rtl/mc_control_p.sv
// mc_control_p: multicycle CPU control FSM with memory handshake, ALU watchdog and trap vector
module mc_control_p
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FUNC_W = 6,
  parameter int ALUOP_W = 5,
  parameter int BR_ALUOP = 0,
  parameter int ALU_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  mc_control_p_if.master bus
);
  localparam logic [OP_W-1:0] OPC_LW = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] OPC_SW = OP_W'(OP_SW);
  localparam logic [OP_W-1:0] OPC_RTYPE = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] OPC_BR = OP_W'(OP_BR);
  localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(OP_ADDI);
  localparam logic [OP_W-1:0] OPC_J = OP_W'(OP_J);
  state_t state, nextState;
  ctrl_t ctrl;
  logic [ALUOP_W-1:0] funcQ, aluOpQ;
  logic [1:0] causeQ;
  logic wdExpire;
  logic [FUNC_W-1:0] unusedFunc;
  logic [OP_W-1:0] op;
  assign op = bus.Opcode;
  assign unusedFunc = bus.AluFunc;
  mc_alu_watchdog #(.ALU_TIMEOUT(ALU_TIMEOUT)) watchdog (
    .clk(clk),
    .reset(reset),
    .clear(state == S_REXEC),
    .enable(state == S_RWAIT && !bus.aludone),
    .expire(wdExpire)
  );
  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_FETCH: nextState = bus.mem_ready ? S_LATCH : S_FETCH;
      S_LATCH: nextState = S_DECODE;
      S_DECODE:
        nextState = (op == OPC_LW || op == OPC_SW) ? S_MEMADDR :
                    op == OPC_RTYPE ? S_REXEC :
                    op == OPC_BR ? S_BRANCH :
                    op == OPC_ADDI ? S_IEXEC :
                    op == OPC_J ? S_JUMP : S_TRAP;
      S_MEMADDR: nextState = op == OPC_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD: nextState = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: nextState = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC: nextState = S_RWAIT;
      S_RWAIT: nextState = bus.aludone ? S_RWB : wdExpire ? S_TRAP : S_RWAIT;
      S_IEXEC: nextState = S_IWB;
      S_TRAP: nextState = bus.trap_clear ? S_VECTOR : S_TRAP;
      default: nextState = S_FETCH;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ctrl <= '0;
      funcQ <= '0;
      aluOpQ <= '0;
      causeQ <= CAUSE_NONE;
    end else begin
      state <= nextState;
      ctrl <= ctrlFor(nextState);
      funcQ <= nextState == S_REXEC ? bus.AluFunc[ALUOP_W-1:0] : funcQ;
      aluOpQ <= nextState == S_REXEC ? bus.AluFunc[ALUOP_W-1:0] :
                (nextState == S_RWAIT || nextState == S_RWB) ? funcQ :
                nextState == S_BRANCH ? ALUOP_W'(BR_ALUOP) : '0;
      causeQ <= nextState == S_VECTOR ? CAUSE_NONE :
                (state == S_DECODE && nextState == S_TRAP) ? CAUSE_ILLEGAL :
                (state == S_RWAIT && nextState == S_TRAP) ? CAUSE_TIMEOUT : causeQ;
    end
  end
  assign bus.mem_req = ctrl.memReq;
  assign bus.MemWriteEn = ctrl.memWriteEn;
  assign bus.IorDSel = ctrl.iorDSel;
  assign bus.IRWriteEn = ctrl.irWriteEn;
  assign bus.PCWrite = ctrl.pcWrite;
  assign bus.BranchEn = ctrl.branchEn;
  assign bus.PCSrcSel = ctrl.pcSrcSel;
  assign bus.ALUASrcSel = ctrl.aluASrcSel;
  assign bus.ALUBSrcSel = ctrl.aluBSrcSel;
  assign bus.AluOp = aluOpQ;
  assign bus.alu_start = ctrl.aluStart;
  assign bus.RegDstSel = ctrl.regDstSel;
  assign bus.MemtoRegSel = ctrl.memtoRegSel;
  assign bus.RegWriteEn = ctrl.regWriteEn;
  assign bus.trap = ctrl.trap;
  assign bus.trap_cause = causeQ;
endmodule

// File: tb/tb_mc_control_p.sv
// tb_mc_control_p: per-instruction expected cycle sequences for directed and random instruction streams
module tb_mc_control_p;
  localparam int OP_W = 6;
  localparam int FUNC_W = 6;
  localparam int ALUOP_W = 5;
  localparam int BR_OP = 3;
  localparam int TMO = 4;
  typedef struct packed {
    logic memReq, memWr, iord, irW, pcW, brEn;
    logic [1:0] pcSrc;
    logic aSrc;
    logic [1:0] bSrc;
    logic [ALUOP_W-1:0] aluOp;
    logic aluStart, regDst, m2r, regW, trap;
    logic [1:0] cause;
  } outs_t;
  typedef struct {
    logic [5:0] op, fn;
    logic mr, ad, tc;
    outs_t exp;
  } vec_t;
  typedef struct {
    string name;
    logic [5:0] op, fn;
    int fw, mw, ad, cw;
  } instr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [1:0] modelCause = 2'b00;
  vec_t vec[$];
  outs_t act;
  logic [5:0] curOp, curFn;
  always #5 clk = ~clk;
  mc_control_p_if #(.OP_W(OP_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W)) bus ();
  mc_control_p #(
    .OP_W(OP_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W), .BR_ALUOP(BR_OP), .ALU_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  assign act = {bus.mem_req, bus.MemWriteEn, bus.IorDSel, bus.IRWriteEn, bus.PCWrite, bus.BranchEn,
                bus.PCSrcSel, bus.ALUASrcSel, bus.ALUBSrcSel, bus.AluOp, bus.alu_start,
                bus.RegDstSel, bus.MemtoRegSel, bus.RegWriteEn, bus.trap, bus.trap_cause};
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic outs_t blank();
    outs_t e;
    e = '0;
    e.cause = modelCause;
    return e;
  endfunction
  task automatic push(input outs_t e, input logic mr, input logic ad, input logic tc);
    vec_t v;
    v.op = curOp;
    v.fn = curFn;
    v.mr = mr;
    v.ad = ad;
    v.tc = tc;
    v.exp = e;
    vec.push_back(v);
  endtask
  task automatic trapSeq(input int cw);
    outs_t e;
    for (int i = 0; i <= cw; i++) begin
      e = blank();
      e.trap = 1'b1;
      push(e, rb(), rb(), i == cw);
    end
    modelCause = 2'b00;
    e = blank();
    e.pcSrc = 2'b11;
    e.pcW = 1'b1;
    push(e, rb(), rb(), rb());
  endtask
  // expected cycle-by-cycle behaviour of one instruction, starting at its fetch
  task automatic build(input instr_t t);
    outs_t e;
    logic [ALUOP_W-1:0] f;
    int n;
    curOp = t.op;
    curFn = t.fn;
    f = t.fn[ALUOP_W-1:0];
    for (int i = 0; i <= t.fw; i++) begin
      e = blank();
      e.memReq = 1'b1;
      push(e, i == t.fw, rb(), rb());
    end
    e = blank();
    e.irW = 1'b1;
    e.pcW = 1'b1;
    e.bSrc = 2'b01;
    push(e, rb(), rb(), rb());
    e = blank();
    e.aSrc = 1'b1;
    e.bSrc = 2'b10;
    push(e, rb(), rb(), rb());
    if (t.op == 6'b100010 || t.op == 6'b100011) begin
      push(e, rb(), rb(), rb());
      for (int i = 0; i <= t.mw; i++) begin
        e = blank();
        e.memReq = 1'b1;
        e.iord = 1'b1;
        if (t.op == 6'b100010) begin
          e.aSrc = 1'b1;
          e.bSrc = 2'b10;
        end else e.memWr = 1'b1;
        push(e, i == t.mw, rb(), rb());
      end
      if (t.op == 6'b100010) begin
        e = blank();
        e.m2r = 1'b1;
        e.regW = 1'b1;
        push(e, rb(), rb(), rb());
      end
    end else if (t.op == 6'b000000) begin
      e = blank();
      e.aSrc = 1'b1;
      e.aluOp = f;
      e.aluStart = 1'b1;
      push(e, rb(), rb(), rb());
      n = (t.ad >= 1 && t.ad <= TMO) ? t.ad : TMO;
      for (int i = 1; i <= n; i++) begin
        e = blank();
        e.aSrc = 1'b1;
        e.aluOp = f;
        push(e, rb(), t.ad == i, rb());
      end
      if (t.ad >= 1 && t.ad <= TMO) begin
        e = blank();
        e.regDst = 1'b1;
        e.regW = 1'b1;
        e.aluOp = f;
        push(e, rb(), rb(), rb());
      end else begin
        modelCause = 2'b10;
        trapSeq(t.cw);
      end
    end else if (t.op == 6'b110000) begin
      e = blank();
      e.aSrc = 1'b1;
      e.aluOp = ALUOP_W'(BR_OP);
      e.pcSrc = 2'b01;
      e.brEn = 1'b1;
      push(e, rb(), rb(), rb());
    end else if (t.op == 6'b100000) begin
      push(e, rb(), rb(), rb());
      e = blank();
      e.regW = 1'b1;
      push(e, rb(), rb(), rb());
    end else if (t.op == 6'b000010) begin
      e = blank();
      e.pcSrc = 2'b10;
      e.pcW = 1'b1;
      push(e, rb(), rb(), rb());
    end else begin
      modelCause = 2'b01;
      trapSeq(t.cw);
    end
  endtask
  task automatic check(input string name, input int idx, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask
  task automatic apply(input string name, input int upto);
    vec_t v;
    int i;
    i = 0;
    while (vec.size() > 0 && i < upto) begin
      v = vec.pop_front();
      @(negedge clk);
      check(name, i, v.exp);
      total++;
      if ($countones({bus.RegWriteEn, bus.MemWriteEn, bus.IRWriteEn}) > 1) begin
        bad++;
        $display("FAIL %s_onehot cyc=%0d got=%b expected at most one set", name, i,
                 {bus.RegWriteEn, bus.MemWriteEn, bus.IRWriteEn});
      end
      bus.Opcode = v.op;
      bus.AluFunc = v.fn;
      bus.mem_ready = v.mr;
      bus.aludone = v.ad;
      bus.trap_clear = v.tc;
      i++;
    end
    vec.delete();
  endtask
  task automatic releaseReset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 0, '0);
  endtask
  instr_t dir[9];
  instr_t t;
  logic [5:0] pool[6];
  initial begin
    dir[0] = '{"lw_delayed", 6'b100010, 6'h11, 3, 2, 0, 0};
    dir[1] = '{"rtype_done3", 6'b000000, 6'b100101, 0, 0, 3, 0};
    dir[2] = '{"rtype_timeout", 6'b000000, 6'b010110, 1, 0, 0, 2};
    dir[3] = '{"illegal", 6'b111111, 6'h3f, 0, 0, 0, 3};
    dir[4] = '{"jump", 6'b000010, 6'h00, 0, 0, 0, 0};
    dir[5] = '{"branch", 6'b110000, 6'h05, 0, 0, 0, 0};
    dir[6] = '{"sw", 6'b100011, 6'h02, 0, 0, 0, 0};
    dir[7] = '{"addi", 6'b100000, 6'h09, 0, 0, 0, 0};
    dir[8] = '{"rtype_edge", 6'b000000, 6'b000111, 0, 0, TMO, 0};
    pool = '{6'b100010, 6'b100011, 6'b000000, 6'b110000, 6'b100000, 6'b000010};
    bus.Opcode = '0;
    bus.AluFunc = '0;
    bus.aludone = 1'b0;
    bus.mem_ready = 1'b1;
    bus.trap_clear = 1'b0;
    @(negedge clk);
    check("reset_state", 0, '0);
    releaseReset();
    foreach (dir[k]) begin
      build(dir[k]);
      apply(dir[k].name, 1000);
    end
    t = '{"rtype_reset", 6'b000000, 6'h15, 0, 0, 0, 0};
    build(t);
    apply(t.name, 6);
    #2 reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1 check("reset_async", 0, '0);
    @(negedge clk);
    check("reset_hold", 0, '0);
    modelCause = 2'b00;
    releaseReset();
    for (int k = 0; k < 200; k++) begin
      t.name = "random";
      t.op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 5)];
      t.fn = 6'($urandom);
      t.fw = $urandom_range(0, 3);
      t.mw = $urandom_range(0, 3);
      t.ad = $urandom_range(0, TMO + 1);
      t.cw = $urandom_range(0, 3);
      build(t);
      apply(t.name, 1000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
